// File: rtl/usb_bit_unstuffer.sv
// USB receive-path bit unstuffer.
// Removes the stuffed 0 that follows every RUN_LEN consecutive 1s in the NRZI-decoded
// stream. Data is forwarded with a valid qualifier, and start/end framing pulses are
// generated for the CRC checker / packet assembler. All outputs are registered and
// have one clock of latency.
// Optional feature: define UNSTUFF_ERR_EN to flag stuffing violations on stuff_err and
// drop the rest of the packet. When it is undefined, a violating 1 is forwarded as data.
module usb_bit_unstuffer #(
    parameter int unsigned RUN_LEN = 6,
    parameter int unsigned BCNT_W  = 13
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_in,
    input  logic              start_unstuffer,
    input  logic              end_unstuffer,
    input  logic              abort,
    output logic              s_out,
    output logic              out_valid,
    output logic              start_crc,
    output logic              end_crc,
    output logic              stuff_err,
    output logic [BCNT_W-1:0] bit_cnt
);

    localparam int unsigned OnesW = $clog2(RUN_LEN + 1);
    localparam logic [OnesW-1:0]  RunMax = OnesW'(RUN_LEN);
    localparam logic [BCNT_W-1:0] CntMax = '1;

`ifdef UNSTUFF_ERR_EN
    typedef enum logic [1:0] {StIdle, StActive, StErr} state_e;
`else
    typedef enum logic [1:0] {StIdle, StActive} state_e;
`endif

    state_e            state_q;
    logic [OnesW-1:0]  ones_cnt_q;
    logic [BCNT_W-1:0] bit_cnt_q;
    logic [BCNT_W-1:0] bit_cnt_inc;
    logic              s_out_q;
    logic              out_valid_q;
    logic              start_crc_q;
    logic              end_crc_q;
    logic              stuff_err_q;

    // Saturating increment of the delivered-bit counter.
    always_comb begin
        bit_cnt_inc = bit_cnt_q;
        if (bit_cnt_q != CntMax) begin
            bit_cnt_inc = bit_cnt_q + 1'b1;
        end
    end

    // Packet FSM: run-length tracking, bit forwarding and registered framing pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            ones_cnt_q  <= '0;
            bit_cnt_q   <= '0;
            s_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            start_crc_q <= 1'b0;
            end_crc_q   <= 1'b0;
            stuff_err_q <= 1'b0;
        end else begin
            // Pulses and the data qualifier are low unless a branch below raises them.
            s_out_q     <= 1'b0;
            out_valid_q <= 1'b0;
            start_crc_q <= 1'b0;
            end_crc_q   <= 1'b0;
            stuff_err_q <= 1'b0;
            if (abort) begin
                state_q    <= StIdle;
                ones_cnt_q <= '0;
                bit_cnt_q  <= '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (start_unstuffer) begin
                            state_q     <= StActive;
                            start_crc_q <= 1'b1;
                            ones_cnt_q  <= '0;
                            bit_cnt_q   <= '0;
                        end
                    end
                    StActive: begin
                        if (end_unstuffer) begin
                            // A pending stuffed bit at end of packet is not an error.
                            state_q    <= StIdle;
                            end_crc_q  <= 1'b1;
                            ones_cnt_q <= '0;
                        end else if (ones_cnt_q == RunMax) begin
                            if (!s_in) begin
                                // Stuffed 0: drop it and restart the run.
                                ones_cnt_q <= '0;
                            end else begin
`ifdef UNSTUFF_ERR_EN
                                stuff_err_q <= 1'b1;
                                state_q     <= StErr;
`else
                                // Violation tolerated: forward it and keep the run saturated
                                // so the next 0 is still treated as stuffing.
                                s_out_q     <= 1'b1;
                                out_valid_q <= 1'b1;
                                bit_cnt_q   <= bit_cnt_inc;
`endif
                            end
                        end else begin
                            s_out_q     <= s_in;
                            out_valid_q <= 1'b1;
                            bit_cnt_q   <= bit_cnt_inc;
                            ones_cnt_q  <= s_in ? ones_cnt_q + 1'b1 : '0;
                        end
                    end
`ifdef UNSTUFF_ERR_EN
                    StErr: begin
                        // Everything is dropped until the packet is closed; no end_crc.
                        if (end_unstuffer) begin
                            state_q    <= StIdle;
                            ones_cnt_q <= '0;
                        end
                    end
`endif
                    default: begin
                        state_q    <= StIdle;
                        ones_cnt_q <= '0;
                    end
                endcase
            end
        end
    end

    assign s_out     = s_out_q;
    assign out_valid = out_valid_q;
    assign start_crc = start_crc_q;
    assign end_crc   = end_crc_q;
    assign stuff_err = stuff_err_q;
    assign bit_cnt   = bit_cnt_q;

endmodule

// File: tb/tb_usb_bit_unstuffer.sv
// Directed bench for usb_bit_unstuffer with hand-computed expectations.
// Honours UNSTUFF_ERR_EN for the violation scenario.
module tb_usb_bit_unstuffer;

    logic        clk;
    logic        rst_n;
    logic        s_in;
    logic        start_unstuffer;
    logic        end_unstuffer;
    logic        abort;
    logic        s_out;
    logic        out_valid;
    logic        start_crc;
    logic        end_crc;
    logic        stuff_err;
    logic [12:0] bit_cnt;

    int total = 0;
    int bad   = 0;

    usb_bit_unstuffer #(
        .RUN_LEN(6),
        .BCNT_W (13)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .s_in           (s_in),
        .start_unstuffer(start_unstuffer),
        .end_unstuffer  (end_unstuffer),
        .abort          (abort),
        .s_out          (s_out),
        .out_valid      (out_valid),
        .start_crc      (start_crc),
        .end_crc        (end_crc),
        .stuff_err      (stuff_err),
        .bit_cnt        (bit_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs, then sample the registered result 1 time unit after the edge.
    task automatic step(input logic b, input logic st, input logic en, input logic ab);
        s_in            = b;
        start_unstuffer = st;
        end_unstuffer   = en;
        abort           = ab;
        @(posedge clk);
        #1;
        s_in            = 1'b0;
        start_unstuffer = 1'b0;
        end_unstuffer   = 1'b0;
        abort           = 1'b0;
    endtask

    // Check all outputs; s_out is only meaningful when out_valid is expected high.
    task automatic expect_all(input string tag, input logic v, input logic so, input logic sc,
                              input logic ec, input logic se, input int bc);
        chk({tag, ".out_valid"}, {31'd0, out_valid}, {31'd0, v});
        if (v) chk({tag, ".s_out"}, {31'd0, s_out}, {31'd0, so});
        chk({tag, ".start_crc"}, {31'd0, start_crc}, {31'd0, sc});
        chk({tag, ".end_crc"}, {31'd0, end_crc}, {31'd0, ec});
        chk({tag, ".stuff_err"}, {31'd0, stuff_err}, {31'd0, se});
        chk({tag, ".bit_cnt"}, {19'd0, bit_cnt}, bc);
    endtask

    // Send one data bit in ACTIVE and check the forwarded result.
    task automatic data(input string tag, input logic b, input logic v, input int bc);
        step(b, 1'b0, 1'b0, 1'b0);
        expect_all(tag, v, b, 1'b0, 1'b0, 1'b0, bc);
    endtask

    initial begin
        logic [7:0] pat;
        int         lows;

        rst_n           = 1'b0;
        s_in            = 1'b0;
        start_unstuffer = 1'b0;
        end_unstuffer   = 1'b0;
        abort           = 1'b0;
        #2;
        expect_all("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Basic unstuffing: 1x6, 0 (stuffed), 1, 0.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_all("t1.start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        for (int i = 1; i <= 6; i++) data("t1.one", 1'b1, 1'b1, i);
        data("t1.stuffed", 1'b0, 1'b0, 6);
        data("t1.b7", 1'b1, 1'b1, 7);
        data("t1.b8", 1'b0, 1'b1, 8);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_all("t1.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);
        step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_all("t1.idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8);

        // No stuffing: 10100101 forwarded in order; a start pulse in ACTIVE is ignored.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_all("t2.start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        pat = 8'b10100101;
        for (int i = 0; i < 8; i++) begin
            step(pat[7-i], (i == 3), 1'b0, 1'b0);
            expect_all("t2.bit", 1'b1, pat[7-i], 1'b0, 1'b0, 1'b0, i + 1);
        end
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t2.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);

        // Back-to-back runs: (1x6, 0) twice -> 12 ones, two drops.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        lows = 0;
        for (int r = 0; r < 2; r++) begin
            for (int i = 1; i <= 6; i++) data("t3.one", 1'b1, 1'b1, r * 6 + i);
            step(1'b0, 1'b0, 1'b0, 1'b0);
            if (!out_valid) lows++;
            chk("t3.drop_cnt", {19'd0, bit_cnt}, (r + 1) * 6);
        end
        chk("t3.lows", lows, 2);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t3.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 12);

        // Violation: seven consecutive ones.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 6; i++) data("t4.one", 1'b1, 1'b1, i);
`ifdef UNSTUFF_ERR_EN
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("t4.viol", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("t4.err_drop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_all("t4.err_nostart", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t4.end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 6);
`else
        data("t4.seventh", 1'b1, 1'b1, 7);
        data("t4.zero_dropped", 1'b0, 1'b0, 7);
        data("t4.after", 1'b1, 1'b1, 8);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t4.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8);
`endif

        // Abort after 5 data bits, then IDLE ignores end, then a fresh packet works.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        pat = 8'b10110000;
        for (int i = 0; i < 5; i++) data("t5.bit", pat[7-i], 1'b1, i + 1);
        step(1'b1, 1'b0, 1'b1, 1'b1);
        expect_all("t5.abort", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        expect_all("t5.idle_end", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        expect_all("t5.idle_data", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        expect_all("t5.restart", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        data("t5.b1", 1'b1, 1'b1, 1);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t5.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1);

        // Async reset mid-packet with four ones pending.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 1; i <= 4; i++) data("t6.one", 1'b1, 1'b1, i);
        #2;
        rst_n = 1'b0;
        #1;
        expect_all("t6.async", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0);
        #2;
        rst_n = 1'b1;
        step(1'b0, 1'b1, 1'b0, 1'b0);
        expect_all("t6.start", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 0);
        data("t6.a", 1'b1, 1'b1, 1);
        data("t6.b", 1'b1, 1'b1, 2);
        data("t6.c", 1'b0, 1'b1, 3);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("t6.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3);

        // Saturation: 8195 zeros must leave bit_cnt at all-ones.
        step(1'b0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 8195; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        expect_all("sat.hold", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8191);
        step(1'b0, 1'b0, 1'b1, 1'b0);
        expect_all("sat.end", 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8191);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/usb_bit_unstuffer.md
Name: usb_bit_unstuffer

Overview:
- Receive-path stage directly downstream of the NRZI decoder. Takes one decoded serial bit per clk and removes the stuffed 0 that follows every RUN_LEN consecutive 1s.
- Forwards the unstuffed bit stream, with a valid qualifier, to the CRC checker / packet assembler.
- Generates the start and end framing pulses for that consumer, and optionally flags bit-stuff violations.

Parameters:
- RUN_LEN, 6, number of consecutive 1s after which a stuffed 0 is expected.
- BCNT_W, 13, width of the delivered-bit counter.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset; asynchronous, active-low.
- s_in  input  1  decoded serial bit from the NRZI decoder.
- start_unstuffer  input  1  one-cycle pulse, packet begins.
- end_unstuffer  input  1  one-cycle pulse, packet ends.
- abort  input  1  synchronous abort; kills the current packet.
- s_out  output  1  unstuffed data bit (registered).
- out_valid  output  1  s_out carries a data bit this cycle.
- start_crc  output  1  one-cycle pulse to downstream, packet begins.
- end_crc  output  1  one-cycle pulse to downstream, packet ended cleanly.
- stuff_err  output  1  one-cycle pulse, stuffing violation (feature only).
- bit_cnt  output  BCNT_W  data bits delivered in the current packet.

Behaviour:
- Reset (async): state=IDLE, ones_cnt=0, bit_cnt=0. Outputs s_out, out_valid, start_crc, end_crc, stuff_err all 0.
- All outputs are registered. Data latency is 1 clk: s_in in cycle N appears on s_out/out_valid in cycle N+1.
- State IDLE:
  - start_unstuffer=1 -> ACTIVE; start_crc=1 next cycle; ones_cnt=0; bit_cnt=0.
  - end_unstuffer is ignored in IDLE.
  - s_in is not data in IDLE or in the start_unstuffer cycle.
- State ACTIVE, each cycle with end_unstuffer=0 and abort=0, s_in is a data bit:
  - ones_cnt<RUN_LEN, s_in=1: forward the bit (out_valid=1, s_out=1), ones_cnt++, bit_cnt++.
  - ones_cnt<RUN_LEN, s_in=0: forward the bit, ones_cnt=0, bit_cnt++.
  - ones_cnt==RUN_LEN, s_in=0: stuffed bit; out_valid=0 next cycle, ones_cnt=0, bit_cnt unchanged.
  - ones_cnt==RUN_LEN, s_in=1: stuffing violation; see Optional Feature.
  - start_unstuffer is ignored in ACTIVE.
- end_unstuffer in ACTIVE:
  - The s_in of that cycle is not data.
  - Next cycle: end_crc=1, out_valid=0. State -> IDLE; ones_cnt=0.
  - bit_cnt holds its final value until the next start_unstuffer.
  - A pending stuffed bit (ones_cnt==RUN_LEN at end) is not an error.
- abort (any state, highest priority):
  - Next cycle: state=IDLE, ones_cnt=0, bit_cnt=0.
  - out_valid, start_crc, end_crc, stuff_err all 0. No end_crc is issued for an aborted packet.
- Priority: abort > end_unstuffer > start_unstuffer > data.
- bit_cnt saturates at all-ones; it never wraps.
- out_valid is never 1 outside ACTIVE, except the single data bit registered in the final ACTIVE cycle.

Optional Feature:
- Macro: UNSTUFF_ERR_EN.
- Defined:
  - A 1 received when ones_cnt==RUN_LEN produces stuff_err=1 for one cycle, with out_valid=0. State -> ERR.
  - ERR drops all bits. end_unstuffer or abort -> IDLE with no end_crc.
  - start_unstuffer is ignored in ERR.
- Not defined:
  - ERR state is absent and stuff_err is tied 0.
  - A 1 received when ones_cnt==RUN_LEN is forwarded as data, bit_cnt++, and ones_cnt holds at RUN_LEN. The next 0 is therefore dropped as a stuffed bit.

Test Plan:
- Basic unstuffing: start, then bits 1,1,1,1,1,1,0,1,0, then end -> s_out 1,1,1,1,1,1,1,0 (stuffed 0 dropped), bit_cnt=8, end_crc one cycle after end.
- No stuffing: start, 8 bits 10100101, end -> all 8 forwarded in order, 1-cycle latency, bit_cnt=8, start_crc/end_crc single pulses.
- Back-to-back runs: 6 ones, 0, 6 ones, 0 -> 12 ones delivered, both 0s dropped, out_valid low exactly twice.
- Violation with UNSTUFF_ERR_EN: 7 consecutive ones -> stuff_err pulse on the 7th; no further out_valid; end -> IDLE, no end_crc. Without the macro: 7 ones delivered, stuff_err stays 0.
- Abort mid-packet after 5 data bits -> next cycle out_valid=0, bit_cnt=0, state IDLE, no end_crc. A following start works normally.
- Async reset asserted mid-packet with ones_cnt=4 -> all outputs 0 immediately. After release, 2 ones and a 0 are forwarded unchanged (counter was cleared).
